sar_conv_sequencer: RTL
=======================

// Module: sar_conv_sequencer
// PURPOSE
//  Initiator side of the SAR ADC conversion handshake: issues cnvst to sar_logic_CS, waits for eoc,
//  captures sar[7:0] and hands samples downstream over valid/ready through a small FIFO.
//  Paces conversions at a programmable interval and flags lost or hung conversions. Sits between
//  the SAR core and the digital back-end.
// PARAMETERS
//  DATA_W         8    width of sar result / dout
//  CNVST_CYCLES   2    clk cycles cnvst is held high per conversion (>=1)
//  TIMEOUT_CYCLES 64   max clk cycles from cnvst fall to eoc rise before abort
//  PERIOD_W       16   width of period input / interval counter
//  FIFO_DEPTH     4    sample buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1         system clock, all logic on rising edge
//  rst          in   1         synchronous, active-high reset
//  en           in   1         1 = run periodic conversions; 0 = finish current, then idle
//  period       in   PERIOD_W  clk cycles between successive cnvst rises; values < CNVST_CYCLES+1 clamp
//  cnvst        out  1         conversion start to SAR core
//  eoc          in   1         end of conversion from SAR core (level, rising edge = result valid)
//  sar          in   DATA_W    SAR result, sampled on the cycle eoc rise is detected
//  dout         out  DATA_W    FIFO head sample
//  dout_valid   out  1         FIFO not empty
//  dout_ready   in   1         downstream accepts dout when dout_valid & dout_ready
//  busy         out  1         FSM not in IDLE
//  overrun      out  1         sticky: sample dropped because FIFO full
//  timeout_err  out  1         sticky: eoc not seen within TIMEOUT_CYCLES
//  clr_err      in   1         synchronous clear of overrun/timeout_err
// BEHAVIOUR
//  Reset: cnvst=0, dout_valid=0, dout=0, busy=0, overrun=0, timeout_err=0; FIFO empty; FSM IDLE;
//   interval counter 0; eoc edge register 0. rst wins over every other input incl. mid-conversion.
//  eoc edge: eoc_d <= eoc each cycle; eoc_rise = eoc & ~eoc_d. Only honoured in WAIT_EOC.
//  FSM:
//   IDLE   : en=1 -> START (next cycle cnvst=1); interval counter loads period.
//   START  : cnvst=1 for exactly CNVST_CYCLES cycles -> WAIT_EOC (cnvst=0).
//   WAIT_EOC: timeout counter counts up; eoc_rise -> CAPTURE; count reaches TIMEOUT_CYCLES -> set
//            timeout_err, -> GAP. eoc_rise on the same cycle as expiry: capture wins, no error.
//   CAPTURE: one cycle; push sar (value registered on eoc_rise cycle) into FIFO if not full,
//            else drop and set overrun. -> GAP.
//   GAP    : wait until interval counter expires (period cycles after previous cnvst rise,
//            clamped min CNVST_CYCLES+1); then en=1 -> START, en=0 -> IDLE.
//  Conversions longer than period: next START is issued immediately after CAPTURE/abort (no queueing).
//  eoc already high on entry to WAIT_EOC gives no rise: must go low then high again.
//  FIFO: push and pop same cycle when full -> both succeed, no overrun; when empty -> no bypass,
//   sample appears on dout_valid next cycle. dout stable while dout_valid & ~dout_ready.
//  clr_err and a new error event in the same cycle: flag ends set (set wins).
//  en deassert mid-conversion: current conversion completes normally, then IDLE. busy=0 only in IDLE.
// STRUCTURE
//  Shared package sar_pkg: FSM state enum (IDLE, START, WAIT_EOC, CAPTURE, GAP), SAR_DATA_W=8
//   constant shared with sar_logic_CS.
//  One sub-module: sar_sample_fifo (synchronous FIFO, DATA_W x FIFO_DEPTH, push/pop/full/empty,
//   same-cycle push+pop when full). FSM, interval and timeout counters stay in top.
// TESTING
//  1 rst=1 4 cycles, en=1, period=40, SAR model returns 8'hA5 eoc 18 cycles after cnvst fall
//    -> cnvst high 2 cycles every 40, dout=A5 dout_valid one cycle after CAPTURE, no flags.
//  2 dout_ready=0, 5 conversions returning 01..05 -> FIFO holds 01..04, overrun=1 after 5th;
//    ready=1 -> 01,02,03,04 in order; clr_err -> overrun=0.
//  3 SAR model never raises eoc, TIMEOUT_CYCLES=64 -> timeout_err=1 exactly 64 cycles after
//    cnvst fall, cnvst re-asserts at next interval, no FIFO push.
//  4 period=1 (clamped) with 18-cycle conversion -> back-to-back conversions, cnvst rises right
//    after each CAPTURE, no overlap of cnvst with WAIT_EOC.
//  5 rst asserted during WAIT_EOC with 2 samples queued -> next cycle all outputs at reset
//    values, FIFO empty; eoc rise afterwards ignored.
//  6 en=0 during START -> conversion completes, sample pushed, FSM to IDLE, busy=0, no new cnvst.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion path: result width and the
// sequencer state encoding used by sar_conv_sequencer.
package sar_pkg;

  localparam int SAR_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_EOC,
    CAPTURE,
    GAP
  } conv_state_e;

endpackage

// File: rtl/sar_sample_fifo.sv
// Synchronous sample FIFO; a push into a full FIFO is legal only together with a pop.
// head reads as zero while empty so the downstream bus idles at a known value.
module sar_sample_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_pop;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign do_pop = pop & ~empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // validity, and head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Initiator side of the SAR conversion handshake: paces cnvst pulses, waits for
// eoc, buffers results for a valid/ready consumer and flags lost or hung conversions.
module sar_conv_sequencer
  import sar_pkg::*;
#(
  parameter int DATA_W         = SAR_DATA_W,
  parameter int CNVST_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PERIOD_W       = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                cnvst,
  input  logic                eoc,
  input  logic [DATA_W-1:0]   sar,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err,
  input  logic                clr_err
);

  localparam int CS_W = $clog2(CNVST_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(CNVST_CYCLES + 1);

  conv_state_e         state;
  conv_state_e         next_state;
  logic [CS_W-1:0]     cs_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [PERIOD_W-1:0] int_cnt;
  logic [PERIOD_W-1:0] eff_period;
  logic [DATA_W-1:0]   sar_q;
  logic                eoc_d;
  logic                eoc_rise;
  logic                cs_done;
  logic                timed_out;
  logic                int_expired;
  logic                start_load;
  logic                push_req;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;

  assign eoc_rise    = eoc & ~eoc_d;
  assign eff_period  = (period < MIN_PERIOD) ? MIN_PERIOD : period;
  assign cs_done     = (cs_cnt == CS_W'(CNVST_CYCLES - 1));
  assign timed_out   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign int_expired = (int_cnt == '0);
  assign start_load  = (next_state == START) && (state != START);
  assign push_req    = (state == CAPTURE);
  assign pop         = dout_valid & dout_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
  assign drop        = push_req & fifo_full & ~pop;
  assign dout_valid  = ~fifo_empty;

  // NOTE: every combinational output gets a default first so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    cnvst      = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:     if (en) next_state = START;
      START: begin
        cnvst = 1'b1;
        if (cs_done) next_state = WAIT_EOC;
      end
      WAIT_EOC: begin
        if (eoc_rise)       next_state = CAPTURE;
        else if (timed_out) next_state = GAP;
      end
      CAPTURE:  next_state = GAP;
      GAP:      if (int_expired) next_state = en ? START : IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cs_cnt      <= '0;
      to_cnt      <= '0;
      int_cnt     <= '0;
      eoc_d       <= 1'b0;
      sar_q       <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state  <= next_state;
      eoc_d  <= eoc;
      cs_cnt <= (state == START) ? cs_cnt + 1'b1 : '0;
      to_cnt <= (state == WAIT_EOC) ? to_cnt + 1'b1 : '0;

      // Interval runs from each cnvst rise; it parks at zero once expired.
      if (start_load)        int_cnt <= eff_period - 1'b1;
      else if (!int_expired) int_cnt <= int_cnt - 1'b1;

      if ((state == WAIT_EOC) && eoc_rise) sar_q <= sar;

      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;

      if ((state == WAIT_EOC) && timed_out && !eoc_rise) timeout_err <= 1'b1;
      else if (clr_err)                                  timeout_err <= 1'b0;
    end
  end

  sar_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req & ~drop),
    .push_data (sar_q),
    .pop       (pop),
    .head      (dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
